array_result_serializer: RTL

Downstream stage of the linear processing array. Captures the CHANNELS parallel column result streams (one word per column per result vector), requantizes each word from the array's result fixed-point format to the output format with round-half-up and saturation, and serializes the vector onto a single AXI-Stream in ascending column order. Column alignment errors and saturation events are flagged for the control block.

---
 rtl/array_result_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/array_result_serializer.sv
// array_result_serializer: captures per-column result words, requantizes with round-half-up
// and saturation, and serializes each vector onto one AXI-Stream in column order.
module array_result_serializer #(
    parameter int CHANNELS            = 4,
    parameter int DATA_WIDTH_IN       = 16,
    parameter int FRACTIONAL_BITS_IN  = 13,
    parameter int DATA_WIDTH_OUT      = 16,
    parameter int FRACTIONAL_BITS_OUT = 13,
    parameter int USER_WIDTH          = 1,
    parameter int ID_WIDTH            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS*DATA_WIDTH_IN-1:0]  s_axis_tdata,
    input  logic [CHANNELS-1:0]                s_axis_tvalid,
    output logic [CHANNELS-1:0]                s_axis_tready,
    input  logic [CHANNELS-1:0]                s_axis_tlast,
    input  logic [CHANNELS*USER_WIDTH-1:0]     s_axis_tuser,
    output logic [DATA_WIDTH_OUT-1:0]          m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [ID_WIDTH-1:0]                m_axis_tid,
    output logic [USER_WIDTH-1:0]              m_axis_tuser,
    output logic                               err_tlast_mismatch,
    output logic                               err_saturated
);
    localparam int SH = FRACTIONAL_BITS_IN - FRACTIONAL_BITS_OUT;
    localparam int WW = DATA_WIDTH_IN + 1 + ((SH < 0) ? -SH : 0);
    localparam int CW = ((WW > DATA_WIDTH_OUT) ? WW : DATA_WIDTH_OUT) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic signed [CW-1:0] MAXV = (ONE << (DATA_WIDTH_OUT - 1)) - ONE;
    localparam logic signed [CW-1:0] MINV = ~MAXV;
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(CHANNELS - 1);

    logic [DATA_WIDTH_IN-1:0]   r_data [CHANNELS];
    logic [USER_WIDTH-1:0]      r_user [CHANNELS];
    logic [CHANNELS-1:0]        r_last, r_full, w_cap, w_drain;
    logic [ID_WIDTH-1:0]        r_idx;
    logic                       r_rdy_en, r_vec_last;
    logic                       w_load, w_vlast, w_hi, w_lo;
    logic signed [DATA_WIDTH_IN-1:0] w_x;
    logic signed [CW-1:0]       w_q;
    logic [DATA_WIDTH_OUT-1:0]  w_y;

    assign s_axis_tready = ~r_full & {CHANNELS{r_rdy_en}};
    assign w_cap   = s_axis_tvalid & s_axis_tready;
    assign w_x     = r_data[r_idx];
    assign w_load  = (!m_axis_tvalid || m_axis_tready) && ((r_idx == '0) ? &r_full : r_full[r_idx]);
    assign w_drain = w_load ? CHANNELS'(1) << r_idx : '0;
    // channel 0 may refill mid-vector, so its tlast is latched when idx 0 is loaded
    assign w_vlast = (r_idx == '0) ? r_last[0] : r_vec_last;

    generate
        if (SH > 0) begin : g_rnd
            localparam logic signed [DATA_WIDTH_IN:0] RND = (DATA_WIDTH_IN + 1)'(1) <<< (SH - 1);
            logic signed [DATA_WIDTH_IN:0] w_sum;
            assign w_sum = (DATA_WIDTH_IN + 1)'(w_x) + RND;
            assign w_q   = CW'(w_sum >>> SH);
        end else if (SH < 0) begin : g_shl
            assign w_q = CW'(w_x) <<< (-SH);
        end else begin : g_id
            assign w_q = CW'(w_x);
        end
    endgenerate

    assign w_hi = w_q > MAXV;
    assign w_lo = w_q < MINV;
    assign w_y  = w_hi ? MAXV[DATA_WIDTH_OUT-1:0] : w_lo ? MINV[DATA_WIDTH_OUT-1:0] : w_q[DATA_WIDTH_OUT-1:0];

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_cap[c]) begin
                r_data[c] <= s_axis_tdata[c*DATA_WIDTH_IN +: DATA_WIDTH_IN];
                r_last[c] <= s_axis_tlast[c];
                r_user[c] <= s_axis_tuser[c*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full             <= '0;
            r_idx              <= '0;
            r_rdy_en           <= 1'b0;
            r_vec_last         <= 1'b0;
            m_axis_tvalid      <= 1'b0;
            m_axis_tdata       <= '0;
            m_axis_tlast       <= 1'b0;
            m_axis_tid         <= '0;
            m_axis_tuser       <= '0;
            err_tlast_mismatch <= 1'b0;
            err_saturated      <= 1'b0;
        end else begin
            r_rdy_en           <= 1'b1;
            r_full             <= (r_full & ~w_drain) | w_cap;
            err_tlast_mismatch <= w_load && (r_idx == '0) && !(&r_last || !(|r_last));
            if (w_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= w_y;
                m_axis_tlast  <= (r_idx == LAST_IDX) && w_vlast;
                m_axis_tid    <= r_idx;
                m_axis_tuser  <= r_user[r_idx];
                err_saturated <= err_saturated | w_hi | w_lo;
                r_idx         <= (r_idx == LAST_IDX) ? '0 : r_idx + ID_WIDTH'(1);
                if (r_idx == '0) r_vec_last <= r_last[0];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule
